// File: rtl/bussed_data_memory_v2.sv
// bussed_data_memory_v2: word-addressed data memory on the shared tristate data bus.
// Address window decode (base/mask), registered 1-cycle read, ready handshake.
// Define DMEM_BYTE_WRITE_EN for byte-lane writes through a read-modify-write MERGE state;
// without it byteEn is ignored and every accepted write is a full-word write.
module bussed_data_memory_v2 #(
    parameter MEM_INIT_FILE = "",
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int TRUE_ADDR_BIT_WIDTH = 11,
    parameter logic [ADDR_BIT_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [ADDR_BIT_WIDTH-1:0] BASE_MASK = 32'hF000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memEn,
    input  logic                        wrtEn,
    input  logic [DATA_BIT_WIDTH/8-1:0] byteEn,
    input  logic [ADDR_BIT_WIDTH-1:0]   addr,
    inout  wire  [DATA_BIT_WIDTH-1:0]   dbus,
    output logic                        rdy
);
    localparam int NB = DATA_BIT_WIDTH / 8;
    (* ram_init_file = MEM_INIT_FILE *) logic [DATA_BIT_WIDTH-1:0] mem [1<<TRUE_ADDR_BIT_WIDTH];
    logic [TRUE_ADDR_BIT_WIDTH-1:0] idx;
    logic [DATA_BIT_WIDTH-1:0] rd_data;
    logic rd_valid, sel, acc, wr_full, unused;
    assign idx = addr[TRUE_ADDR_BIT_WIDTH+1:2];
    assign sel = memEn && ((addr & BASE_MASK) == BASE_ADDR);
    assign acc = sel && rdy && !reset;
    assign dbus = rd_valid ? rd_data : 'z;
    assign unused = ^{byteEn, MEM_INIT_FILE == ""};
    // Registered read: data is on the bus only during the cycle after acceptance
    always_ff @(posedge clk)
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_valid <= acc && !wrtEn;
            if (acc && !wrtEn) rd_data <= mem[idx];
        end
`ifdef DMEM_BYTE_WRITE_EN
    typedef enum logic {IDLE, MERGE} state_t;
    state_t state, state_nx;
    logic [TRUE_ADDR_BIT_WIDTH-1:0] m_idx;
    logic [DATA_BIT_WIDTH-1:0] m_data, m_old, merged;
    logic [NB-1:0] m_be;
    logic wr_part, wr_merge;
    assign wr_full = acc && wrtEn && (&byteEn);
    assign wr_part = acc && wrtEn && !(&byteEn) && (|byteEn);
    // State register; reset abandons a pending merge
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // Next state: a partial write spends exactly one edge in MERGE
    always_comb
        state_nx = (state == MERGE) ? IDLE : (wr_part ? MERGE : IDLE);
    // Outputs: ready only when idle with the bus free; merged word from latched lanes
    always_comb begin
        rdy = (state == IDLE) && !rd_valid;
        wr_merge = (state == MERGE) && !reset;
        merged = m_old;
        for (int b = 0; b < NB; b++)
            if (m_be[b]) merged[b*8 +: 8] = m_data[b*8 +: 8];
    end
    // Capture the partial write together with the word it modifies
    always_ff @(posedge clk)
        if (wr_part) begin
            m_idx <= idx;
            m_data <= dbus;
            m_be <= byteEn;
            m_old <= mem[idx];
        end
    // RAM write port: merged word from MERGE, otherwise an accepted full-word write
    always_ff @(posedge clk)
        if (wr_merge) mem[m_idx] <= merged;
        else if (wr_full) mem[idx] <= dbus;
`else
    assign rdy = !rd_valid;
    assign wr_full = acc && wrtEn;
    // RAM write port: every accepted write stores the whole bus word
    always_ff @(posedge clk)
        if (wr_full) mem[idx] <= dbus;
`endif
endmodule

// File: tb/tb_bussed_data_memory_v2.sv
// tb_bussed_data_memory_v2: directed table-driven bench for bussed_data_memory_v2.
module tb_bussed_data_memory_v2;
    localparam bit BYTE =
`ifdef DMEM_BYTE_WRITE_EN
        1'b1;
`else
        1'b0;
`endif
    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] e;
    } vec_t;
    logic clk = 0, reset = 1, memEn = 0, wrtEn = 0, drv = 0;
    logic [3:0] byteEn = '1;
    logic [31:0] addr = '0, wdata = '0;
    wire [31:0] dbus;
    logic rdy;
    int tests = 0, fails = 0;
    assign dbus = drv ? wdata : 'z;
    always #5 clk = ~clk;
    bussed_data_memory_v2 dut (
        .clk(clk), .reset(reset), .memEn(memEn), .wrtEn(wrtEn),
        .byteEn(byteEn), .addr(addr), .dbus(dbus), .rdy(rdy)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic check_rel(input string name);
        tests++;
        if (!($isunknown(dbus) || dbus == 32'h0)) begin
            fails++;
            $display("FAIL %s: dbus driven with %h, expected released", name, dbus);
        end
    endtask
    task automatic wait_rdy(input string name);
        for (int i = 0; i < 8 && !rdy; i++) @(negedge clk);
        tests++;
        if (!rdy) begin
            fails++;
            $display("FAIL %s: rdy got 0 after 8 cycles, expected 1", name);
        end
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        memEn = 1; wrtEn = 1; addr = a; wdata = d; byteEn = be; drv = 1;
        wait_rdy("wr_rdy");
        @(posedge clk); #1;
        memEn = 0; wrtEn = 0; drv = 0;
    endtask
    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic r);
        @(negedge clk);
        memEn = 1; wrtEn = 0; addr = a;
        wait_rdy("rd_rdy");
        @(posedge clk); #1;
        memEn = 0;
        @(negedge clk);
        d = dbus;
        r = rdy;
    endtask
    initial begin
        logic [31:0] d;
        logic r;
        vec_t v[17];
        v[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        v[1]  = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF};
        v[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 32'h0};
        v[3]  = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, BYTE ? 32'hDEAD_AAEF : 32'h0000_AA00};
        v[4]  = '{1'b1, 32'h1000_0010, 32'h1234_5678, 4'hF, 32'h0};
        v[5]  = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, BYTE ? 32'hDEAD_AAEF : 32'h0000_AA00};
        v[6]  = '{1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF, 32'h0};
        v[7]  = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hCAFE_F00D};
        v[8]  = '{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 32'h0};
        v[9]  = '{1'b1, 32'h0000_0014, 32'h1122_3344, 4'h0, 32'h0};
        v[10] = '{1'b0, 32'h0000_0014, 32'h0, 4'hF, BYTE ? 32'hA5A5_A5A5 : 32'h1122_3344};
        v[11] = '{1'b1, 32'h0000_0018, 32'hAABB_CCDD, 4'hF, 32'h0};
        v[12] = '{1'b1, 32'h0000_0018, 32'h5500_0066, 4'b1001, 32'h0};
        v[13] = '{1'b0, 32'h0000_0018, 32'h0, 4'hF, BYTE ? 32'h55BB_CC66 : 32'h5500_0066};
        v[14] = '{1'b1, 32'h0000_1FFC, 32'h0F0F_0F0F, 4'hF, 32'h0};
        v[15] = '{1'b0, 32'h0000_1FFC, 32'h0, 4'hF, 32'h0F0F_0F0F};
        v[16] = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hCAFE_F00D};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rel("reset_dbus");
        check("reset_rdy", {31'b0, rdy}, 32'h1);
        check("reset_rdvalid", {31'b0, dut.rd_valid}, 32'h0);
        reset = 0;
        for (int i = 0; i < 17; i++)
            if (v[i].wr) wr(v[i].a, v[i].d, v[i].be);
            else begin
                rd(v[i].a, d, r);
                check($sformatf("rd%0d_data", i), d, v[i].e);
                check($sformatf("rd%0d_rdy", i), {31'b0, r}, 32'h0);
            end
        @(negedge clk);
        memEn = 1; wrtEn = 0; addr = 32'h1000_0010;
        @(posedge clk); #1;
        memEn = 0;
        @(negedge clk);
        check_rel("oow_read_dbus");
        check("oow_read_rdy", {31'b0, rdy}, 32'h1);
        @(negedge clk);
        memEn = 1; wrtEn = 1; addr = 32'h0000_0010; wdata = 32'h0000_00FF; byteEn = 4'b0001; drv = 1;
        wait_rdy("merge_rdy");
        @(posedge clk); #1;
        memEn = 0; wrtEn = 0; drv = 0; reset = 1;
        @(negedge clk);
        check("merge_busy_rdy", {31'b0, rdy}, BYTE ? 32'h0 : 32'h1);
        @(posedge clk); #1;
        reset = 0;
        rd(32'h0000_0010, d, r);
        check("merge_reset_data", d, BYTE ? 32'hDEAD_AAEF : 32'h0000_00FF);
        @(negedge clk);
        @(negedge clk);
        memEn = 1; wrtEn = 0; addr = 32'h0000_0018;
        wait_rdy("rstrd_rdy");
        @(posedge clk); #1;
        memEn = 0; reset = 1;
        @(negedge clk);
        check("rstrd_valid_data", dbus, BYTE ? 32'h55BB_CC66 : 32'h5500_0066);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check_rel("rstrd_release");
        check("rstrd_rdy", {31'b0, rdy}, 32'h1);
        check("rstrd_rdvalid", {31'b0, dut.rd_valid}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
